// File: rtl/mat_mult_pkg.sv
// Shared types for the sequential GF(2)/boolean matrix multiplier.
package mat_mult_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    GF2_MUL  = 2'b00,
    BOOL_MUL = 2'b01,
    GF2_ACC  = 2'b10
  } op_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } mm_state_t;

  // The reserved encoding 2'b11 behaves as a plain GF(2) product.
  function automatic op_mode_t decode_mode(input logic [MODE_W-1:0] m);
    case (m)
      2'b01:   return BOOL_MUL;
      2'b10:   return GF2_ACC;
      default: return GF2_MUL;
    endcase
  endfunction

endpackage

// File: rtl/gf2_row_dot.sv
// One row of A against all columns of B: XOR-of-ANDs (GF(2)) or OR-of-ANDs (boolean).
module gf2_row_dot #(
  parameter int A_COLS = 8,
  parameter int B_COLS = 1
) (
  input  logic [A_COLS-1:0]        i_a_row,
  input  logic [A_COLS*B_COLS-1:0] i_b,
  input  logic                     i_bool_mode,
  output logic [B_COLS-1:0]        o_c
);

  // Reduce each column of B against the row; both reductions are built, the flag picks one.
  always_comb begin
    logic w_x;
    logic w_o;
    logic w_p;
    o_c = '0;
    for (int j = 0; j < B_COLS; j++) begin
      w_x = 1'b0;
      w_o = 1'b0;
      for (int k = 0; k < A_COLS; k++) begin
        w_p = i_a_row[k] & i_b[k*B_COLS+j];
        w_x = w_x ^ w_p;
        w_o = w_o | w_p;
      end
      o_c[j] = i_bool_mode ? w_o : w_x;
    end
  end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential matrix multiplier: LANES rows of C per cycle, valid/ready on both sides.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for an operation to capture
// COMPUTE | writing LANES rows per edge into the shadow register
// DONE    | out_valid=1, result held until out_ready
module mat_mult_seq
  import mat_mult_pkg::*;
#(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 8,
  parameter int B_COLS = 1,
  parameter int LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MODE_W-1:0]        op_mode,
  input  logic [A_ROWS*A_COLS-1:0] A_data_in,
  input  logic [A_COLS*B_COLS-1:0] B_data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [A_ROWS*B_COLS-1:0] C_data_out
);

  localparam int N     = A_ROWS / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = A_ROWS * B_COLS;

  if (LANES < 1 || (A_ROWS % LANES) != 0) begin : g_lanes_check
    $error("mat_mult_seq: LANES (%0d) must divide A_ROWS (%0d)", LANES, A_ROWS);
  end

  mm_state_t                  r_state;
  mm_state_t                  w_state_next;
  logic                       w_capture;
  logic                       w_release;
  logic                       w_last;
  logic [CNT_W-1:0]           r_cnt;
  logic [A_ROWS*A_COLS-1:0]   r_a;
  logic [A_COLS*B_COLS-1:0]   r_b;
  op_mode_t                   r_mode;
  logic [CW-1:0]              r_acc;
  logic [CW-1:0]              r_shadow;
  logic [CW-1:0]              r_c_out;
  logic [CW-1:0]              w_shadow_next;
  logic                       w_bool_mode;
  logic [A_COLS-1:0]          w_a_row [LANES];
  logic [B_COLS-1:0]          w_dot   [LANES];

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign C_data_out  = r_c_out;
  assign w_last      = (r_cnt == CNT_W'(N - 1));
  assign w_bool_mode = (r_mode == BOOL_MUL);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode plus the capture/release strobes used by the datapath.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_capture    = 1'b1;
          w_state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pick the A rows handled this cycle from the row counter.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_a_row[l] = r_a[(int'(r_cnt) * LANES + l) * A_COLS +: A_COLS];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf2_row_dot #(
      .A_COLS (A_COLS),
      .B_COLS (B_COLS)
    ) u_dot (
      .i_a_row     (w_a_row[l]),
      .i_b         (r_b),
      .i_bool_mode (w_bool_mode),
      .o_c         (w_dot[l])
    );
  end

  // Merge this cycle's row group (with the accumulator folded in for GF2_ACC) into the shadow.
  always_comb begin
    logic [B_COLS-1:0] w_grp;
    int                w_row;
    w_shadow_next = r_shadow;
    for (int l = 0; l < LANES; l++) begin
      w_row = int'(r_cnt) * LANES + l;
      w_grp = w_dot[l];
      if (r_mode == GF2_ACC) w_grp = w_grp ^ r_acc[w_row*B_COLS +: B_COLS];
      w_shadow_next[w_row*B_COLS +: B_COLS] = w_grp;
    end
  end

  // Operand capture, row counter, shadow/result registers and accumulator.
  // C_data_out only moves on the final COMPUTE edge so partial rows never show.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= GF2_MUL;
      r_acc    <= '0;
      r_shadow <= '0;
      r_c_out  <= '0;
    end else begin
      if (w_capture) begin
        r_a    <= A_data_in;
        r_b    <= B_data_in;
        r_mode <= decode_mode(op_mode);
        r_cnt  <= '0;
      end
      if (r_state == COMPUTE) begin
        r_shadow <= w_shadow_next;
        if (w_last) begin
          r_cnt   <= '0;
          r_c_out <= w_shadow_next;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_release) r_acc <= (r_mode == GF2_ACC) ? r_c_out : '0;
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed vectors on the default configuration plus a reference-model sweep on wider variants.
module tb_mat_mult_seq;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  b;
    logic [1:0]  mode;
    logic [3:0]  exp_c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op_mode;
  logic [31:0] A_data_in;
  logic [7:0]  B_data_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  C_data_out;
  logic        start_wide = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [31:0] IDENT = 32'h0804_0201;

  always #5 clk = ~clk;

  mat_mult_seq #(.A_ROWS(4), .A_COLS(8), .B_COLS(1), .LANES(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_mode    (op_mode),
    .A_data_in  (A_data_in),
    .B_data_in  (B_data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .C_data_out (C_data_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Independent reference for a 4x8 A against an 8xbc B.
  function automatic logic [11:0] ref_mm(input logic [31:0] a, input logic [23:0] b, input int bc,
                                         input logic [1:0] mode, input logic [11:0] acc);
    logic [11:0] c;
    logic x, o, p;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < bc; j++) begin
        x = 1'b0;
        o = 1'b0;
        for (int k = 0; k < 8; k++) begin
          p = a[r*8+k] & b[k*bc+j];
          x ^= p;
          o |= p;
        end
        c[r*bc+j] = (mode == 2'b01) ? o : x;
        if (mode == 2'b10) c[r*bc+j] = c[r*bc+j] ^ acc[r*bc+j];
      end
    end
    return c;
  endfunction

  // Capture one operation and wait for out_valid; checks latency, result, no early change.
  task automatic start_op(input string nm, input logic [31:0] a, input logic [7:0] b,
                          input logic [1:0] mode, input logic [3:0] exp_c);
    logic [3:0] prev;
    logic       leak;
    int         lat;
    prev = C_data_out;
    leak = 1'b0;
    lat  = 0;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    A_data_in = a;
    B_data_in = b;
    op_mode   = mode;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    A_data_in = ~a;
    B_data_in = ~b;
    op_mode   = ~mode;
    while (!out_valid && lat < 20) begin
      if (C_data_out !== prev) leak = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_c"}, 32'(C_data_out), 32'(exp_c));
    chk({nm, "_no_leak"}, 32'(leak), 32'd0);
  endtask

  task automatic finish_op(input string nm, input logic [3:0] exp_c);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_idle_vr"}, 32'({out_valid, in_ready}), 32'b01);
    chk({nm, "_retain"}, 32'(C_data_out), 32'(exp_c));
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int L = (g == 0) ? 2 : 4;
    logic        iv, ir, ov, ordy, done;
    logic [1:0]  md;
    logic [31:0] a;
    logic [23:0] b;
    logic [11:0] c;

    mat_mult_seq #(.A_ROWS(4), .A_COLS(8), .B_COLS(3), .LANES(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv),
      .in_ready   (ir),
      .op_mode    (md),
      .A_data_in  (a),
      .B_data_in  (b),
      .out_valid  (ov),
      .out_ready  (ordy),
      .C_data_out (c)
    );

    initial begin
      logic [11:0] acc, w_exp;
      int lat;
      iv = 1'b0; ordy = 1'b0; md = '0; a = '0; b = '0; done = 1'b0; acc = '0;
      wait (start_wide);
      for (int i = 0; i < 20; i++) begin
        a     = $urandom;
        b     = 24'($urandom);
        md    = 2'($urandom_range(0, 3));
        w_exp = ref_mm(a, b, 3, md, acc);
        acc   = (md == 2'b10) ? w_exp : '0;
        @(negedge clk);
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv  = 1'b0;
        a   = $urandom;
        b   = 24'($urandom);
        lat = 0;
        while (!ov && lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
        chk($sformatf("wide_l%0d_lat_%0d", L, i), 32'(lat), 32'(4 / L));
        chk($sformatf("wide_l%0d_c_%0d", L, i), 32'(c), 32'(w_exp));
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t tv [10];
    int   t;
    tv[0] = '{IDENT,        8'hA5, 2'b00, 4'h5};
    tv[1] = '{32'h000000FF, 8'hFF, 2'b00, 4'h0};
    tv[2] = '{32'h000000FF, 8'hFF, 2'b01, 4'h1};
    tv[3] = '{IDENT,        8'h0F, 2'b10, 4'hF};
    tv[4] = '{IDENT,        8'h0F, 2'b10, 4'h0};
    tv[5] = '{IDENT,        8'h0F, 2'b00, 4'hF};
    tv[6] = '{IDENT,        8'h0F, 2'b10, 4'hF};
    tv[7] = '{32'h000000FF, 8'hFF, 2'b11, 4'h0};
    tv[8] = '{32'hFFFFFFFF, 8'h01, 2'b01, 4'hF};
    tv[9] = '{32'h000F0703, 8'hFF, 2'b00, 4'h2};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_mode = '0; A_data_in = '0; B_data_in = '0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(C_data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].mode, tv[i].exp_c);
      finish_op($sformatf("vec%0d", i), tv[i].exp_c);
    end

    // Stall in DONE with a stray in_valid pulse that must be dropped.
    start_op("stall", IDENT, 8'hA5, 2'b00, 4'h5);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        @(negedge clk);
        in_valid = 1'b1; A_data_in = 32'h000000FF; B_data_in = 8'hFF; op_mode = 2'b01;
      end
      if (i == 2) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("stall_vr_%0d", i), 32'({out_valid, in_ready}), 32'b10);
      chk($sformatf("stall_c_%0d", i), 32'(C_data_out), 32'h5);
    end
    finish_op("stall", 4'h5);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_not_queued", 32'({out_valid, in_ready}), 32'b01);

    // Asynchronous reset in the middle of COMPUTE.
    @(negedge clk);
    in_valid = 1'b1; A_data_in = IDENT; B_data_in = 8'h0F; op_mode = 2'b10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_c", 32'(C_data_out), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_release_ready", 32'(in_ready), 32'd1);
    start_op("post_rst", IDENT, 8'h0F, 2'b10, 4'hF);
    finish_op("post_rst", 4'hF);

    start_wide = 1'b1;
    t = 0;
    while (!(g_w[0].done && g_w[1].done) && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("wide_sweep_done", 32'(g_w[0].done && g_w[1].done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
